// File: rtl/jelly_axi4s_frame_controller_if.sv
// AXI4-Stream pixel bus (tdata/tvalid/tready) between the frame controller
// and its upstream source / downstream datapath.
//   master : drives tdata, tvalid; receives tready
//   slave  : receives tdata, tvalid; drives tready
interface jelly_axi4s_frame_controller_if #(
  parameter int TDATA_WIDTH = 24
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/jelly_axi4s_frame_controller.sv
// Frame controller: gates an AXI4-Stream pixel stream into whole frames of
// out_param_width x out_param_height pixels, counts completed frames and
// reloads frame geometry only on frame boundaries.
//   aclk/areset/aclken          : clock, async active-high reset, clock enable
//   ctl_enable/oneshot/update   : run level, single-frame level, reload request
//   param_width/param_height    : requested geometry (0 is clamped to 1)
//   out_param_width/height      : geometry currently in force
//   status_busy/frame_count     : not idle / completed-frame counter
//   status_update_ack           : one-cycle pulse when geometry is loaded
//   irq_frame_end               : one-cycle pulse after the last pixel handshake
//   s_axi4s / m_axi4s           : upstream pixels in, gated pixels out
module jelly_axi4s_frame_controller #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 10,
  parameter int TDATA_WIDTH = 24,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   aclken,

  input  logic                   ctl_enable,
  input  logic                   ctl_oneshot,
  input  logic                   ctl_update,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,

  output logic [X_WIDTH-1:0]     out_param_width,
  output logic [Y_WIDTH-1:0]     out_param_height,

  output logic                   status_busy,
  output logic [COUNT_WIDTH-1:0] status_frame_count,
  output logic                   status_update_ack,
  output logic                   irq_frame_end,

  jelly_axi4s_frame_controller_if.slave  s_axi4s,
  jelly_axi4s_frame_controller_if.master m_axi4s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [X_WIDTH-1:0]     X_ONE = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]     Y_ONE = Y_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  state_t                 state_q,   state_d;
  logic [X_WIDTH-1:0]     x_q,       x_d;
  logic [Y_WIDTH-1:0]     y_q,       y_d;
  logic [X_WIDTH-1:0]     width_q,   width_d;
  logic [Y_WIDTH-1:0]     height_q,  height_d;
  logic [COUNT_WIDTH-1:0] count_q,   count_d;
  logic                   pending_q, pending_d;
  logic                   ack_q,     ack_d;
  logic                   irq_q,     irq_d;

  logic run;
  logic handshake;
  logic x_last;
  logic y_last;
  logic load;

  // Zero-latency pass-through while running; gated off in IDLE/DONE.
  assign run            = (state_q == ST_RUN);
  assign m_axi4s.tdata  = s_axi4s.tdata;
  assign m_axi4s.tvalid = run & s_axi4s.tvalid & aclken;
  assign s_axi4s.tready = run & m_axi4s.tready & aclken;

  assign handshake = run & aclken & s_axi4s.tvalid & m_axi4s.tready;
  assign x_last    = (x_q == width_q  - X_ONE);
  assign y_last    = (y_q == height_q - Y_ONE);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    width_d   = width_q;
    height_d  = height_q;
    count_d   = count_q;
    pending_d = pending_q;
    ack_d     = 1'b0;
    irq_d     = 1'b0;
    load      = 1'b0;

    if (aclken) begin
      pending_d = pending_q | ctl_update;

      case (state_q)
        ST_IDLE: begin
          if (ctl_enable) begin
            state_d = ST_RUN;
            load    = 1'b1;
          end
        end

        ST_RUN: begin
          if (handshake) begin
            if (x_last) begin
              x_d = '0;
              if (y_last) begin
                y_d     = '0;
                irq_d   = 1'b1;
                count_d = count_q + C_ONE;
                // Pending reload (including one arriving this cycle) is
                // applied only here, on the frame boundary.
                load    = pending_d;
                if (ctl_oneshot) begin
                  state_d = ST_DONE;
                end else if (!ctl_enable) begin
                  state_d = ST_IDLE;
                end
              end else begin
                y_d = y_q + Y_ONE;
              end
            end else begin
              x_d = x_q + X_ONE;
            end
          end
        end

        ST_DONE: begin
          if (!ctl_enable) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (load) begin
        width_d   = (param_width  == '0) ? X_ONE : param_width;
        height_d  = (param_height == '0) ? Y_ONE : param_height;
        x_d       = '0;
        y_d       = '0;
        ack_d     = 1'b1;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      width_q   <= '0;
      height_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      width_q   <= width_d;
      height_q  <= height_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign out_param_width    = width_q;
  assign out_param_height   = height_q;
  assign status_busy        = (state_q != ST_IDLE);
  assign status_frame_count = count_q;
  assign status_update_ack  = ack_q;
  assign irq_frame_end      = irq_q;

endmodule

// File: tb/tb_jelly_axi4s_frame_controller.sv
// Directed bench for jelly_axi4s_frame_controller: inputs change and outputs
// are sampled on the falling clock edge; handshakes occur on the rising edge.
module tb_jelly_axi4s_frame_controller;

  localparam int XW = 10;
  localparam int YW = 10;
  localparam int DW = 24;
  localparam int CW = 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic          aclken;
  logic          ctl_enable;
  logic          ctl_oneshot;
  logic          ctl_update;
  logic [XW-1:0] param_width;
  logic [YW-1:0] param_height;
  logic [XW-1:0] out_param_width;
  logic [YW-1:0] out_param_height;
  logic          status_busy;
  logic [CW-1:0] status_frame_count;
  logic          status_update_ack;
  logic          irq_frame_end;

  jelly_axi4s_frame_controller_if #(.TDATA_WIDTH(DW)) s_if ();
  jelly_axi4s_frame_controller_if #(.TDATA_WIDTH(DW)) m_if ();

  jelly_axi4s_frame_controller #(
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW),
    .TDATA_WIDTH(DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .aclk              (aclk),
    .areset            (areset),
    .aclken            (aclken),
    .ctl_enable        (ctl_enable),
    .ctl_oneshot       (ctl_oneshot),
    .ctl_update        (ctl_update),
    .param_width       (param_width),
    .param_height      (param_height),
    .out_param_width   (out_param_width),
    .out_param_height  (out_param_height),
    .status_busy       (status_busy),
    .status_frame_count(status_frame_count),
    .status_update_ack (status_update_ack),
    .irq_frame_end     (irq_frame_end),
    .s_axi4s           (s_if.slave),
    .m_axi4s           (m_if.master)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    areset       = 1'b1;
    aclken       = 1'b1;
    ctl_enable   = 1'b0;
    ctl_oneshot  = 1'b0;
    ctl_update   = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    m_if.tready  = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // Enables with the given geometry and continuous traffic; returns on the
  // falling edge after the load (first pixel handshakes on the next rise).
  task automatic start(input logic [XW-1:0] w, input logic [YW-1:0] h);
    param_width  = w;
    param_height = h;
    ctl_enable   = 1'b1;
    s_if.tvalid  = 1'b1;
    m_if.tready  = 1'b1;
    @(negedge aclk);
  endtask

  int hs_cnt;
  int irq_cnt;
  logic hs;
  logic exp_irq;
  logic [31:0] rnd;
  int exp_cnt [5] = '{1, 2, 3, 0, 1};

  initial begin
    param_width  = '0;
    param_height = '0;

    // ---- reset state ----
    do_reset();
    chk("rst_busy",   status_busy, 0);
    chk("rst_count",  status_frame_count, 0);
    chk("rst_width",  out_param_width, 0);
    chk("rst_height", out_param_height, 0);
    chk("rst_sready", s_if.tready, 0);
    chk("rst_mvalid", m_if.tvalid, 0);
    chk("rst_ack",    status_update_ack, 0);
    chk("rst_irq",    irq_frame_end, 0);

    // ---- 4x2 continuous, two frames ----
    start(10'd4, 10'd2);
    chk("a_ack",    status_update_ack, 1);
    chk("a_busy",   status_busy, 1);
    chk("a_width",  out_param_width, 4);
    chk("a_height", out_param_height, 2);
    for (int i = 1; i <= 16; i++) begin
      s_if.tdata = DW'(i * 3 + 1);
      #1;
      chk("a_mvalid", m_if.tvalid, 1);
      chk("a_tdata",  m_if.tdata, i * 3 + 1);
      @(negedge aclk);
      chk("a_irq", irq_frame_end, (i == 8 || i == 16) ? 1 : 0);
      if (i == 8)  chk("a_count1", status_frame_count, 1);
      if (i == 16) chk("a_count2", status_frame_count, 2);
    end

    // ---- oneshot: exactly one frame, then DONE ----
    do_reset();
    ctl_oneshot = 1'b1;
    start(10'd4, 10'd2);
    hs_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (s_if.tready && m_if.tvalid) hs_cnt++;
      @(negedge aclk);
    end
    chk("b_hs",     hs_cnt, 8);
    chk("b_busy",   status_busy, 1);
    chk("b_sready", s_if.tready, 0);
    chk("b_mvalid", m_if.tvalid, 0);
    chk("b_count",  status_frame_count, 1);
    ctl_enable = 1'b0;
    @(negedge aclk);
    chk("b_idle", status_busy, 0);
    ctl_enable  = 1'b1;
    ctl_oneshot = 1'b0;
    @(negedge aclk);
    chk("b_restart_ack", status_update_ack, 1);
    chk("b_restart_rdy", s_if.tready, 1);

    // ---- width update 4->6 requested mid-frame ----
    do_reset();
    start(10'd4, 10'd2);
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        param_width = 10'd6;
        ctl_update  = 1'b1;
      end else begin
        ctl_update  = 1'b0;
      end
      @(negedge aclk);
      chk("c_ack", status_update_ack, (i == 8) ? 1 : 0);
      chk("c_irq", irq_frame_end, (i == 8 || i == 20) ? 1 : 0);
      if (i == 7) chk("c_width_old", out_param_width, 4);
      if (i == 8) chk("c_width_new", out_param_width, 6);
    end

    // ---- enable dropped mid-frame ----
    do_reset();
    start(10'd4, 10'd2);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) ctl_enable = 1'b0;
      @(negedge aclk);
      chk("d_irq", irq_frame_end, (i == 8) ? 1 : 0);
      if (i == 7) chk("d_busy_mid", status_busy, 1);
    end
    chk("d_busy",   status_busy, 0);
    chk("d_sready", s_if.tready, 0);
    chk("d_count",  status_frame_count, 1);

    // ---- back-pressure and clock-enable toggling, two 4x2 frames ----
    do_reset();
    start(10'd4, 10'd2);
    hs_cnt  = 0;
    irq_cnt = 0;
    exp_irq = 1'b0;
    for (int c = 0; c < 400 && hs_cnt < 16; c++) begin
      chk("e_irq", irq_frame_end, exp_irq);
      if (irq_frame_end) irq_cnt++;
      rnd         = $urandom;
      aclken      = rnd[0] | rnd[1];
      s_if.tvalid = rnd[2] | rnd[3];
      m_if.tready = rnd[4] | rnd[5];
      s_if.tdata  = DW'(24'hA00000 + hs_cnt);
      #1;
      chk("e_mvalid", m_if.tvalid, s_if.tvalid & aclken);
      chk("e_sready", s_if.tready, m_if.tready & aclken);
      hs      = m_if.tvalid & m_if.tready;
      exp_irq = 1'b0;
      if (hs) begin
        chk("e_data", m_if.tdata, 32'hA00000 + hs_cnt);
        hs_cnt++;
        exp_irq = ((hs_cnt % 8) == 0);
      end
      @(negedge aclk);
    end
    chk("e_irq_last", irq_frame_end, exp_irq);
    if (irq_frame_end) irq_cnt++;
    chk("e_hs",       hs_cnt, 16);
    chk("e_irq_cnt",  irq_cnt, 2);
    chk("e_count",    status_frame_count, 2);
    aclken      = 1'b1;
    s_if.tvalid = 1'b0;

    // ---- zero geometry clamps to 1x1; 2-bit frame count wraps ----
    do_reset();
    start(10'd0, 10'd0);
    chk("f_width",  out_param_width, 1);
    chk("f_height", out_param_height, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("f_irq",   irq_frame_end, 1);
      chk("f_count", status_frame_count, exp_cnt[k]);
    end

    // ---- asynchronous reset in the middle of a frame ----
    do_reset();
    start(10'd4, 10'd2);
    for (int i = 0; i < 4; i++) @(negedge aclk);
    chk("g_busy_pre", status_busy, 1);
    #2;
    areset = 1'b1;
    #1;
    chk("g_busy",   status_busy, 0);
    chk("g_count",  status_frame_count, 0);
    chk("g_width",  out_param_width, 0);
    chk("g_height", out_param_height, 0);
    chk("g_sready", s_if.tready, 0);
    chk("g_mvalid", m_if.tvalid, 0);
    chk("g_ack",    status_update_ack, 0);
    chk("g_irq",    irq_frame_end, 0);
    ctl_enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("g_irq_after",   irq_frame_end, 0);
    chk("g_count_after", status_frame_count, 0);
    chk("g_busy_after",  status_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
